// File: rtl/regfile_wb_arbiter.sv
// Purpose: shares the register-file write port among NUM_REQ result producers and tracks outstanding writes per register.
// Latency: grant is combinational (0 cycles); the accepted write appears on wr_* one cycle later for exactly one cycle.
// Backpressure: at most one one-hot req_ready per cycle; losers hold req_rd/req_data until granted. No grants while rst is high.
//
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   req_valid/req_rd/req_data      - packed per-requester write-back requests (requester i at slice i)
//   req_ready                      - one-hot grant, combinational from req_valid and arbiter state
//   wr_en/wr_addr/wr_data          - registered write toward the register file (x0 writes suppressed)
//   iss_valid/iss_rd               - issuing instruction marks its destination busy
//   chk_rs1/chk_rs2/chk_rd, hazard - hazard query against the registered scoreboard
//   busy                           - scoreboard, bit n set while a write to xn is outstanding
//
// Build option: define RR_ARB_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).

module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [XLEN-1:0]           wr_data,
    input  logic                      iss_valid,
    input  logic [ADDR_W-1:0]         iss_rd,
    input  logic [ADDR_W-1:0]         chk_rs1,
    input  logic [ADDR_W-1:0]         chk_rs2,
    input  logic [ADDR_W-1:0]         chk_rd,
    output logic                      hazard,
    output logic [31:0]               busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic              gnt_found;
    logic [IDX_W-1:0]  gnt_idx;
    logic [ADDR_W-1:0] gnt_rd;
    logic [XLEN-1:0]   gnt_data;
    logic              wr_fire;
    logic [31:0]       busy_q;
    logic [31:0]       busy_nxt;

`ifdef RR_ARB_EN
    // Index of the most recent winner; search begins one past it.
    logic [IDX_W-1:0] ptr_q;
    int               cand;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
        if (rst) begin
            gnt_found = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else if (gnt_found) begin
            ptr_q <= gnt_idx;
        end
    end
`else
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && req_valid[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(k);
            end
        end
        if (rst) begin
            gnt_found = 1'b0;
        end
    end
`endif

    assign req_ready = gnt_found ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign gnt_rd    = req_rd[gnt_idx*ADDR_W +: ADDR_W];
    assign gnt_data  = req_data[gnt_idx*XLEN +: XLEN];

    // Writes to x0 are accepted but never reach the register file.
    assign wr_fire   = gnt_found && (gnt_rd != '0);

    // Clear first, then set: a same-edge issue to the register being
    // written back means a newer producer is still pending.
    always_comb begin
        busy_nxt = busy_q;
        if (wr_fire) begin
            busy_nxt[gnt_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy_q  <= '0;
        end else begin
            wr_en  <= wr_fire;
            busy_q <= busy_nxt;
            if (wr_fire) begin
                wr_addr <= gnt_rd;
                wr_data <= gnt_data;
            end
        end
    end

    assign busy   = busy_q;
    assign hazard = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int XL = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_rd;
    logic [N*XL-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XL-1:0]   wr_data;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   chk_rs1;
    logic [AW-1:0]   chk_rs2;
    logic [AW-1:0]   chk_rd;
    logic            hazard;
    logic [31:0]     busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(XL), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .chk_rd    (chk_rd),
        .hazard    (hazard),
        .busy      (busy)
    );

    typedef struct {
        logic [N-1:0]  ready;
        logic          hazard;
        logic [31:0]   busy;
        logic          wr_en;
        logic          addr_known;
        logic [AW-1:0] wr_addr;
        logic [XL-1:0] wr_data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Per-requester stimulus state
    logic          v[N];
    logic [AW-1:0] r[N];
    logic [XL-1:0] d[N];
    logic [N-1:0]  acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = v[i];
            req_rd[i*AW +: AW]    = r[i];
            req_data[i*XL +: XL]  = d[i];
        end
    endtask

    // Sample handshakes before the edge, then move to just after the edge.
    task automatic tick();
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drop_accepted();
        for (int i = 0; i < N; i++) begin
            if (acc[i]) v[i] = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int  n;
        logic pending;
        n = 0;
        pending = 1'b0;
        for (int i = 0; i < N; i++) pending |= v[i];
        while (pending && n < budget) begin
            tick();
            drop_accepted();
            drive();
            n++;
            pending = 1'b0;
            for (int i = 0; i < N; i++) pending |= v[i];
        end
        if (pending) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: requests still pending after %0d cycles at %0t", budget, $time);
        end
    endtask

    // Reference model: evaluates the arbitration and scoreboard rules once per
    // cycle from the applied inputs and queues the expected DUT view.
    initial begin : model
        logic [31:0]   busy_m;
        logic          wen_m;
        logic          known_m;
        logic [AW-1:0] wa_m;
        logic [XL-1:0] wd_m;
        logic [AW-1:0] wrd;
        int            win;
`ifdef RR_ARB_EN
        int            last;
        last = N - 1;
`endif
        exp_t          e;
        busy_m  = '0;
        wen_m   = 1'b0;
        known_m = 1'b1;
        wa_m    = '0;
        wd_m    = '0;
        forever begin
            @(negedge clk);
            win = -1;
            if (!rst) begin
`ifdef RR_ARB_EN
                for (int k = 1; k <= N; k++) begin
                    if (win < 0 && req_valid[(last + k) % N]) win = (last + k) % N;
                end
`else
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && req_valid[k]) win = k;
                end
`endif
            end
            e.ready      = (win >= 0) ? (N'(1) << win) : '0;
            e.busy       = busy_m;
            e.hazard     = busy_m[chk_rs1] | busy_m[chk_rs2] | busy_m[chk_rd];
            e.wr_en      = wen_m;
            e.addr_known = known_m;
            e.wr_addr    = wa_m;
            e.wr_data    = wd_m;
            exp_q.push_back(e);

            if (rst) begin
                busy_m  = '0;
                wen_m   = 1'b0;
                known_m = 1'b1;
                wa_m    = '0;
                wd_m    = '0;
`ifdef RR_ARB_EN
                last    = N - 1;
`endif
            end else begin
                wen_m = 1'b0;
                if (win >= 0) begin
                    wrd = req_rd[win*AW +: AW];
`ifdef RR_ARB_EN
                    last = win;
`endif
                    if (wrd != 0) begin
                        wen_m     = 1'b1;
                        wa_m      = wrd;
                        wd_m      = req_data[win*XL +: XL];
                        known_m   = 1'b1;
                        busy_m[wrd] = 1'b0;
                    end else begin
                        known_m = 1'b0;
                    end
                end
                if (iss_valid && iss_rd != 0) busy_m[iss_rd] = 1'b1;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("req_ready", 32'(req_ready), 32'(e.ready));
                check("busy",      busy,           e.busy);
                check("hazard",    32'(hazard),    32'(e.hazard));
                check("wr_en",     32'(wr_en),     32'(e.wr_en));
                if (e.addr_known) begin
                    check("wr_addr", 32'(wr_addr), 32'(e.wr_addr));
                    check("wr_data", wr_data,      e.wr_data);
                end
            end
        end
    end

    initial begin : stimulus
        rst       = 1'b1;
        iss_valid = 1'b0;
        iss_rd    = '0;
        chk_rs1   = '0;
        chk_rs2   = '0;
        chk_rd    = '0;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0;
            r[i] = '0;
            d[i] = '0;
        end
        drive();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single requester 1 write to x5
        v[1] = 1'b1; r[1] = 5; d[1] = 32'hDEADBEEF;
        drive();
        drain(10);
        repeat (2) tick();

        // All three requesting continuously
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1;
            r[i] = AW'(i + 1);
            d[i] = $urandom;
        end
        drive();
        repeat (6) tick();
        drain(20);
        tick();

        // Write to x0 is accepted and dropped
        v[0] = 1'b1; r[0] = 0; d[0] = 32'h1234;
        drive();
        drain(5);
        tick();

        // Scoreboard set, hazard, clear by write-back
        iss_valid = 1'b1; iss_rd = 7; chk_rs2 = 7;
        tick();
        iss_valid = 1'b0;
        tick();
        v[2] = 1'b1; r[2] = 7; d[2] = $urandom;
        drive();
        drain(5);
        repeat (2) tick();
        chk_rs2 = 0;

        // Same-edge set and clear of x9
        iss_valid = 1'b1; iss_rd = 9;
        tick();
        v[0] = 1'b1; r[0] = 9; d[0] = $urandom;
        drive();
        tick();
        iss_valid = 1'b0;
        drop_accepted();
        drive();
        drain(5);
        tick();

        // Build busy = 0x0F0E, then reset with requests pending
        iss_valid = 1'b1;
        foreach (d[i]) d[i] = $urandom;
        for (int b = 1; b < 12; b++) begin
            if (b <= 3 || b >= 8) begin
                iss_rd = AW'(b);
                tick();
            end
        end
        iss_valid = 1'b0;
        chk_rs1 = 8; chk_rd = 3;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1;
            r[i] = AW'(12 + i);
        end
        rst = 1'b1;
        drive();
        tick();
        rst = 1'b0;
        drain(20);
        tick();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!v[i] || acc[i]) begin
                    v[i] = ($urandom_range(0, 99) < 60);
                    r[i] = AW'($urandom_range(0, 31));
                    d[i] = $urandom;
                end
            end
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_rd    = AW'($urandom_range(0, 31));
            chk_rs1   = AW'($urandom_range(0, 31));
            chk_rs2   = AW'($urandom_range(0, 31));
            chk_rd    = AW'($urandom_range(0, 31));
            rst       = ($urandom_range(0, 199) == 0);
            drive();
        end
        rst = 1'b0;
        iss_valid = 1'b0;
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        drive();
        repeat (3) tick();
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
